muldiv_ctrl: RTL



---
 rtl/muldiv_ctrl_pkg.sv | 33 +++
 rtl/muldiv_ctrl_if.sv | 26 ++
 rtl/muldiv_ctrl_div_iter.sv | 103 ++++++++++
 rtl/muldiv_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM encodings and result payload for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned STATE_W = 2;

  // EX-stage op codes shared with the ALU decode
  localparam logic [OP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [OP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Sequencer states
  localparam logic [STATE_W-1:0] MD_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] MD_DIV  = 2'd1;
  localparam logic [STATE_W-1:0] MD_DONE = 2'd2;

  // Pending HI/LO write
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // True for ops that occupy the sequencer (everything except MTHI/MTLO)
  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer bundle.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic [OP_W-1:0] op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            start_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;

  // EX stage side
  modport master (
    output op_i, a_i, b_i, start_i, flush_i,
    input  stall_o, busy_o, hi_o, lo_o
  );

  // Sequencer side
  modport slave (
    input  op_i, a_i, b_i, start_i, flush_i,
    output stall_o, busy_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring divider datapath: one quotient bit per step, sign fix-up on the outputs.
module muldiv_ctrl_div_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int unsigned CNT_W = 6;

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             done_q, done_d;

  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;
  logic [XLEN:0]    trial;

  // Magnitudes for signed divide; raw operands for unsigned
  always_comb begin
    abs_a = (signed_i && dividend_i[XLEN-1]) ? XLEN'(-dividend_i) : dividend_i;
    abs_b = (signed_i && divisor_i[XLEN-1])  ? XLEN'(-divisor_i)  : divisor_i;
  end

  // Shift remainder:dividend left one and try subtracting the divisor
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
  end

  // Load operands or advance one restoring step
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = done_q;
    if (load_i) begin
      rem_d     = '0;
      quo_d     = abs_a;
      dvs_d     = abs_b;
      cnt_d     = '0;
      neg_quo_d = signed_i & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      neg_rem_d = signed_i & dividend_i[XLEN-1];
      done_d    = 1'b0;
    end else if (step_i) begin
      if (!trial[XLEN]) begin
        rem_d = trial[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
      cnt_d  = cnt_q + CNT_W'(1);
      // Flag goes high for the cycle that performs the final step
      done_d = (cnt_q == CNT_W'(DIV_ITERS - 2));
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  // Quotient negated on sign mismatch; remainder follows the dividend sign
  always_comb begin
    quotient_o  = neg_quo_q ? XLEN'(-quo_q) : quo_q;
    remainder_o = neg_rem_q ? XLEN'(-rem_q) : rem_q;
    done_o      = done_q;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner beside the EX-stage ALU.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_ctrl_if.slave bus
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  hilo_t              res_q, res_d;
  logic               use_div_q, use_div_d;

  logic               md_op_c;
  logic               is_mul_c;
  logic               is_signed_c;
  logic               stall_c;
  logic               div_load_c;
  logic               div_step_c;
  logic [2*XLEN-1:0]  mul_a;
  logic [2*XLEN-1:0]  mul_b;
  logic [2*XLEN-1:0]  product;
  logic [XLEN-1:0]    div_quo;
  logic [XLEN-1:0]    div_rem;
  logic               div_done;

  // Op decode
  always_comb begin
    md_op_c     = bus.start_i & is_md_op(bus.op_i);
    is_mul_c    = (bus.op_i == EXE_MULT_OP) || (bus.op_i == EXE_MULTU_OP);
    is_signed_c = (bus.op_i == EXE_MULT_OP) || (bus.op_i == EXE_DIV_OP);
  end

  // Single 64-bit multiplier; sign extension selects MULT vs MULTU
  always_comb begin
    mul_a   = {{XLEN{is_signed_c & bus.a_i[XLEN-1]}}, bus.a_i};
    mul_b   = {{XLEN{is_signed_c & bus.b_i[XLEN-1]}}, bus.b_i};
    product = mul_a * mul_b;
  end

  muldiv_ctrl_div_iter #(
    .DIV_ITERS (DIV_ITERS)
  ) u_div_iter (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (div_load_c),
    .step_i      (div_step_c),
    .signed_i    (is_signed_c),
    .dividend_i  (bus.a_i),
    .divisor_i   (bus.b_i),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  // Next-state, HI/LO update and stall decode
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_d      = res_q;
    use_div_d  = use_div_q;
    div_load_c = 1'b0;
    div_step_c = 1'b0;
    stall_c    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          if (md_op_c) begin
            stall_c = 1'b1;
            if (is_mul_c) begin
              res_d     = product;
              use_div_d = 1'b0;
              state_d   = MD_DONE;
            end else if (bus.b_i == '0) begin
              res_d     = '{hi: bus.a_i, lo: '1};
              use_div_d = 1'b0;
              state_d   = MD_DONE;
            end else begin
              div_load_c = 1'b1;
              use_div_d  = 1'b1;
              state_d    = MD_DIV;
            end
          end else if (bus.op_i == EXE_MTHI_OP) begin
            hi_d = bus.a_i;
          end else if (bus.op_i == EXE_MTLO_OP) begin
            lo_d = bus.a_i;
          end
        end
      end
      MD_DIV: begin
        if (bus.flush_i) begin
          state_d = MD_IDLE;
        end else begin
          stall_c    = 1'b1;
          div_step_c = 1'b1;
          if (div_done) begin
            state_d = MD_DONE;
          end
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
        if (!bus.flush_i) begin
          if (use_div_q) begin
            hi_d = div_rem;
            lo_d = div_quo;
          end else begin
            hi_d = res_q.hi;
            lo_d = res_q.lo;
          end
        end
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // State and HI/LO registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= MD_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      res_q     <= '0;
      use_div_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_q     <= res_d;
      use_div_q <= use_div_d;
    end
  end

  // Stall must react in the issue cycle, so it stays combinational
  assign bus.stall_o = stall_c;
  assign bus.busy_o  = (state_q != MD_IDLE);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule
